axis_frame_scheduler: RTL and testbench

//   Frame-atomic egress scheduler that merges N_QUEUE AXI-Stream queues (outputs of the per-class

---
 rtl/axis_frame_scheduler.sv | 160 ++++++++++++++++
 tb/tb_axis_frame_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_scheduler.sv
// Frame-atomic AXI-Stream egress scheduler.
// Merges N_QUEUE input queues onto one output port, one whole frame at a time.
// Arbitration is either strict priority or weighted round-robin.
// Each queue also gets a counter of the frames it has completed.
module axis_frame_scheduler #(
  parameter int N_QUEUE      = 3,
  parameter int DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int MODE         = 1,
  parameter int WEIGHT_WIDTH = 4,
  parameter logic [N_QUEUE*WEIGHT_WIDTH-1:0] WEIGHTS = {4'd1, 4'd1, 4'd1},
  parameter int CNT_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [N_QUEUE*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_QUEUE*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [N_QUEUE-1:0]              s_axis_tvalid,
  output logic [N_QUEUE-1:0]              s_axis_tready,
  input  logic [N_QUEUE-1:0]              s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            grant_valid,
  output logic [$clog2(N_QUEUE)-1:0]      grant_idx,
  output logic [N_QUEUE*CNT_WIDTH-1:0]    stat_frames
);

  localparam int IDX_W = $clog2(N_QUEUE);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [WEIGHT_WIDTH-1:0] credit_reg, credit_next;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_move;
  logic                    beat_last;
  logic [WEIGHT_WIDTH-1:0] weight_eff [N_QUEUE];

  // (base + off) modulo N_QUEUE, with off in 1..N_QUEUE
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_QUEUE) sum = sum - N_QUEUE;
    return IDX_W'(sum);
  endfunction

  // A programmed weight of zero behaves as one frame per turn
  for (genvar gi = 0; gi < N_QUEUE; gi++) begin : g_weight
    assign weight_eff[gi] = (WEIGHTS[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                            ? WEIGHT_WIDTH'(1) : WEIGHTS[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Arbitration winner among currently valid queues
  always_comb begin
    win_idx  = '0;
    win_move = 1'b0;
    if (MODE == 0) begin
      // descending scan so the lowest valid index is written last
      for (int i = N_QUEUE - 1; i >= 0; i--) begin
        if (s_axis_tvalid[i]) win_idx = IDX_W'(i);
      end
    end else if (s_axis_tvalid[rr_ptr_reg] && credit_reg != '0) begin
      win_idx = rr_ptr_reg;
    end else begin
      // scan rr_ptr+1 .. rr_ptr+N; offset N is the current queue itself,
      // so it only wins when no other queue is valid
      win_move = 1'b1;
      win_idx  = rr_ptr_reg;
      for (int k = N_QUEUE; k >= 1; k--) begin
        if (s_axis_tvalid[wrap_add(rr_ptr_reg, k)]) win_idx = wrap_add(rr_ptr_reg, k);
      end
    end
  end

  // Next-state: grant in IDLE, release on the last beat, credit bookkeeping
  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    credit_next    = credit_reg;
    case (state_reg)
      IDLE: begin
        if (enable && (|s_axis_tvalid)) begin
          state_next     = XFER;
          grant_idx_next = win_idx;
          if (MODE != 0 && win_move) begin
            rr_ptr_next = win_idx;
            credit_next = weight_eff[win_idx];
          end
        end
      end
      XFER: begin
        if (beat_last) begin
          state_next = IDLE;
          if (MODE != 0 && credit_reg != '0) credit_next = credit_reg - WEIGHT_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      credit_reg    <= weight_eff[0];
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      credit_reg    <= credit_next;
    end
  end

  // Output mux: granted queue is passed straight through, everything else idles at zero
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_reg == XFER) begin
      for (int i = 0; i < N_QUEUE; i++) begin
        if (grant_idx_reg == IDX_W'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign beat_last   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign grant_valid = (state_reg == XFER);
  assign grant_idx   = grant_idx_reg;

  // Per-queue completed-frame counters, free-running with wrap
  for (genvar gi = 0; gi < N_QUEUE; gi++) begin : g_stat
    logic [CNT_WIDTH-1:0] frames_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frames_reg <= '0;
      end else if (beat_last && grant_idx_reg == IDX_W'(gi)) begin
        frames_reg <= frames_reg + CNT_WIDTH'(1);
      end
    end
    assign stat_frames[gi*CNT_WIDTH +: CNT_WIDTH] = frames_reg;
  end

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Directed bench for axis_frame_scheduler.
// Instance 0: round-robin with weights 1/1/1, instance 1: round-robin with weights 2/1/1,
// instance 2: strict priority. Each queue is fed from a beat memory. Every output beat is
// logged, and frame order, beat contents and counters are compared to hand-derived values.
module tb_axis_frame_scheduler;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk, rst_n, enable, m_tready, tog;
  logic [191:0] s_tdata  [3];
  logic [23:0]  s_tkeep  [3];
  logic [2:0]   s_tvalid [3];
  logic [2:0]   s_tlast  [3];
  logic [2:0]   s_tready [3];
  logic [63:0]  m_tdata  [3];
  logic [7:0]   m_tkeep  [3];
  logic         m_tvalid [3];
  logic         m_tlast  [3];
  logic         grant_valid [3];
  logic [1:0]   grant_idx [3];
  logic [95:0]  stat [3];

  beat_t src_mem [3][3][64];
  int    src_head [3][3];
  int    src_tail [3][3];
  beat_t obs_beat [3][64];
  int    obs_cyc [3][64];
  int    obs_n [3];
  int    ord [3][32];
  int    ord_n [3];
  logic [2:0] fire_s [3];
  int    cyc, checks, failures, sp_ready_leak;
  int    t2_exp [8] = '{0, 0, 1, 2, 0, 0, 1, 2};

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    axis_frame_scheduler #(
      .N_QUEUE(3), .DATA_WIDTH(64), .KEEP_WIDTH(8),
      .MODE((gi == 2) ? 0 : 1), .WEIGHT_WIDTH(4),
      .WEIGHTS((gi == 1) ? 12'h112 : 12'h111), .CNT_WIDTH(32)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s_axis_tdata(s_tdata[gi]), .s_axis_tkeep(s_tkeep[gi]),
      .s_axis_tvalid(s_tvalid[gi]), .s_axis_tready(s_tready[gi]), .s_axis_tlast(s_tlast[gi]),
      .m_axis_tdata(m_tdata[gi]), .m_axis_tkeep(m_tkeep[gi]), .m_axis_tvalid(m_tvalid[gi]),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[gi]),
      .grant_valid(grant_valid[gi]), .grant_idx(grant_idx[gi]), .stat_frames(stat[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic beat_t make_beat(input int d, input int q, input int f, input int b, input int n);
    beat_t bt;
    bt.data = (64'(d) << 40) | (64'(q) << 32) | (64'(f) << 16) | 64'(b);
    bt.last = (b == n - 1);
    bt.keep = bt.last ? 8'h07 : 8'hFF;
    return bt;
  endfunction

  task automatic update_inputs();
    for (int d = 0; d < 3; d++) begin
      for (int q = 0; q < 3; q++) begin
        if (src_head[d][q] < src_tail[d][q]) begin
          s_tdata[d][q*64 +: 64] = src_mem[d][q][src_head[d][q]].data;
          s_tkeep[d][q*8 +: 8]   = src_mem[d][q][src_head[d][q]].keep;
          s_tlast[d][q]          = src_mem[d][q][src_head[d][q]].last;
          s_tvalid[d][q]         = 1'b1;
        end else begin
          s_tdata[d][q*64 +: 64] = '0;
          s_tkeep[d][q*8 +: 8]   = '0;
          s_tlast[d][q]          = 1'b0;
          s_tvalid[d][q]         = 1'b0;
        end
      end
    end
  endtask

  task automatic push_frame(input int d, input int q, input int f, input int n);
    for (int b = 0; b < n; b++) begin
      src_mem[d][q][src_tail[d][q]] = make_beat(d, q, f, b, n);
      src_tail[d][q]++;
    end
    update_inputs();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ord(input int d, input int n, input string tag);
    int c = 0;
    while (ord_n[d] < n && c < 300) begin tick(); c++; end
    check(tag, 96'(ord_n[d]), 96'(n));
  endtask

  task automatic wait_beats(input int d, input int n, input string tag);
    int c = 0;
    while (obs_n[d] < n && c < 300) begin tick(); c++; end
    check(tag, 96'(obs_n[d]), 96'(n));
  endtask

  // Source/sink model: sample handshakes just before each rising edge, advance just after it
  initial begin
    forever begin
      @(negedge clk);
      #4;
      for (int d = 0; d < 3; d++) begin
        fire_s[d] = s_tvalid[d] & s_tready[d];
        if (m_tvalid[d] && m_tready && obs_n[d] < 64) begin
          obs_beat[d][obs_n[d]] = {m_tdata[d], m_tkeep[d], m_tlast[d]};
          obs_cyc[d][obs_n[d]]  = cyc;
          obs_n[d]++;
          if (m_tlast[d] && ord_n[d] < 32) begin
            ord[d][ord_n[d]] = int'(grant_idx[d]);
            ord_n[d]++;
            $display("frame dut%0d q%0d cycle %0d", d, grant_idx[d], cyc);
          end
        end
      end
      if (grant_valid[2] && grant_idx[2] == 2'd2 && s_tready[2][0]) sp_ready_leak++;
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++)
        for (int q = 0; q < 3; q++)
          if (fire_s[d][q]) src_head[d][q]++;
      if (tog) m_tready = ~m_tready;
      update_inputs();
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; m_tready = 1'b1; tog = 1'b0;
    update_inputs();
    #3;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_grant_valid_%0d", d), 96'(grant_valid[d]), 96'd0);
      check($sformatf("rst_m_tvalid_%0d", d), 96'(m_tvalid[d]), 96'd0);
      check($sformatf("rst_s_tready_%0d", d), 96'(s_tready[d]), 96'd0);
      check($sformatf("rst_stat_%0d", d), stat[d], 96'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Round-robin, equal weights: three 2-beat frames per queue
    for (int f = 0; f < 3; f++)
      for (int q = 0; q < 3; q++) push_frame(0, q, f, 2);
    enable = 1'b1;
    wait_ord(0, 9, "t1_done");
    for (int i = 0; i < 9; i++) check($sformatf("t1_order_%0d", i), 96'(ord[0][i]), 96'(i % 3));
    for (int q = 0; q < 3; q++) check($sformatf("t1_stat_q%0d", q), 96'(stat[0][q*32 +: 32]), 96'd3);

    // Round-robin, weights 2/1/1
    for (int f = 0; f < 4; f++) push_frame(1, 0, f, 1);
    for (int f = 0; f < 2; f++) begin push_frame(1, 1, f, 1); push_frame(1, 2, f, 1); end
    wait_ord(1, 8, "t2_done");
    for (int i = 0; i < 8; i++) check($sformatf("t2_order_%0d", i), 96'(ord[1][i]), 96'(t2_exp[i]));
    check("t2_stat", stat[1], {32'd2, 32'd2, 32'd4});

    // Strict priority: q0 arriving mid-frame must wait for the q2 frame
    push_frame(2, 2, 0, 4);
    wait_beats(2, 2, "t3_beat2");
    push_frame(2, 0, 1, 2);
    wait_ord(2, 2, "t3_done");
    check("t3_first_q", 96'(ord[2][0]), 96'd2);
    check("t3_second_q", 96'(ord[2][1]), 96'd0);
    check("t3_q2_last_beat", 96'(obs_beat[2][3]), 96'(make_beat(2, 2, 0, 3, 4)));
    check("t3_q0_ready_leak", 96'(sp_ready_leak), 96'd0);
    check("t3_idle_gap", 96'(obs_cyc[2][4] - obs_cyc[2][3]), 96'd2);

    // Output backpressure toggling during a 5-beat frame
    tog = 1'b1;
    push_frame(0, 1, 9, 5);
    wait_ord(0, 10, "t4_done");
    tog = 1'b0;
    m_tready = 1'b1;
    for (int b = 0; b < 5; b++)
      check($sformatf("t4_beat_%0d", b), 96'(obs_beat[0][18 + b]), 96'(make_beat(0, 1, 9, b, 5)));
    check("t4_beat_count", 96'(obs_n[0]), 96'd23);

    // enable dropped mid-frame: frame completes, then no new grant
    push_frame(0, 0, 10, 4);
    wait_beats(0, 25, "t5_beat2");
    enable = 1'b0;
    push_frame(0, 2, 11, 1);
    wait_ord(0, 11, "t5_frame_done");
    for (int i = 0; i < 5; i++) tick();
    check("t5_hold_grant_valid", 96'(grant_valid[0]), 96'd0);
    check("t5_hold_s_tready", 96'(s_tready[0]), 96'd0);
    check("t5_hold_frames", 96'(ord_n[0]), 96'd11);
    check("t5_last_beat", 96'(obs_beat[0][26]), 96'(make_beat(0, 0, 10, 3, 4)));
    enable = 1'b1;
    wait_ord(0, 12, "t5_resume");
    check("t5_resume_q", 96'(ord[0][11]), 96'd2);

    // Asynchronous reset in the middle of a frame
    push_frame(1, 1, 20, 5);
    wait_beats(1, 10, "t6_beat2");
    #1 rst_n = 1'b0;
    #1;
    check("t6_m_tvalid", 96'(m_tvalid[1]), 96'd0);
    check("t6_m_tdata", 96'(m_tdata[1]), 96'd0);
    check("t6_grant_valid", 96'(grant_valid[1]), 96'd0);
    check("t6_s_tready", 96'(s_tready[1]), 96'd0);
    check("t6_stat", stat[1], 96'd0);
    src_head[1][1] = src_tail[1][1];
    push_frame(1, 1, 21, 1);
    push_frame(1, 0, 22, 1);
    tick();
    rst_n = 1'b1;
    wait_ord(1, 10, "t6_done");
    check("t6_first_after_rst", 96'(ord[1][8]), 96'd0);
    check("t6_second_after_rst", 96'(ord[1][9]), 96'd1);
    check("t6_stat_after", stat[1], {32'd0, 32'd1, 32'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
